// File: rtl/mylstar_input_pkg.sv
// Shared constants and types for the mylstar input conditioner.
// Holds mod ids, joystick bit indices, FSM/arbiter enums, helpers.
package mylstar_input_pkg;

  localparam logic [7:0] MOD_QBERT    = 8'd0;
  localparam logic [7:0] MOD_QUB      = 8'd1;
  localparam logic [7:0] MOD_MPLANETS = 8'd2;
  localparam logic [7:0] MOD_KRULL    = 8'd3;
  localparam logic [7:0] MOD_CURVEBAL = 8'd4;

  localparam int JOY_DN   = 0;
  localparam int JOY_UP   = 1;
  localparam int JOY_RT   = 2;
  localparam int JOY_LT   = 3;
  localparam int JOY_B1   = 4;
  localparam int JOY_S1   = 5;
  localparam int JOY_S2   = 6;
  localparam int JOY_COIN = 7;
  localparam int JOY_B2   = 8;
  localparam int JOY_B3   = 9;
  localparam int JOY_B4   = 10;
  localparam int JOY_B5   = 11;

  typedef enum logic [1:0] {
    IDLE, PULSE, GAP, WAIT_REL
  } coin_state_t;

  typedef enum logic [2:0] {
    NONE, DN, UP, RT, LT
  } dir_t;

  // v = {lt, rt, up, dn}; priority down > up > right > left
  function automatic dir_t dir_pick(input logic [3:0] v);
    if (v[0]) return DN;
    if (v[1]) return UP;
    if (v[2]) return RT;
    if (v[3]) return LT;
    return NONE;
  endfunction

  function automatic logic [3:0] dir_onehot(input dir_t d);
    case (d)
      DN:      return 4'b0001;
      UP:      return 4'b0010;
      RT:      return 4'b0100;
      LT:      return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mylstar_input_cond_debounce.sv
// Per-bit tick-sampled debouncer: a bit flips only after DEB_TICKS
// consecutive mismatching ticks. Ports: clk_sys, reset, tick, din, dout.
module input_debounce
  import mylstar_input_pkg::*;
#(
  parameter int WIDTH     = 12,
  parameter int DEB_TICKS = 4
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             tick,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int CW = $clog2(DEB_TICKS + 1);

  logic [WIDTH-1:0]         dout_q, dout_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;

  always_comb begin
    dout_d = dout_q;
    cnt_d  = cnt_q;
    if (tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (din[i] == dout_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CW'(DEB_TICKS - 1)) begin
          dout_d[i] = ~dout_q[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dout_q <= '0;
      cnt_q  <= '0;
    end else begin
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/mylstar_input_cond.sv
// Input conditioner for mylstar_board: sync, debounce, 4-way arbiter,
// coin pulse FSM, per-game byte mapping. Ports: clk_sys, reset, joy_in,
// test_sw, mod in; ip1710, ip4740, coin_busy out.
module mylstar_input_cond
  import mylstar_input_pkg::*;
#(
  parameter int TICK_DIV       = 50000,
  parameter int DEB_TICKS      = 4,
  parameter int COIN_ON_TICKS  = 60,
  parameter int COIN_OFF_TICKS = 60
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [15:0] joy_in,
  input  logic        test_sw,
  input  logic [7:0]  mod,
  output logic [7:0]  ip1710,
  output logic [7:0]  ip4740,
  output logic        coin_busy
);

  localparam int TW   = $clog2(TICK_DIV + 1);
  localparam int CMAX = (COIN_ON_TICKS > COIN_OFF_TICKS) ?
                        COIN_ON_TICKS : COIN_OFF_TICKS;
  localparam int CCW  = $clog2(CMAX + 1);

  logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
  logic           tick;
  logic [11:0]    sync1_q, sync2_q;
  logic [11:0]    d;
  logic           tsw_q;
  logic [3:0]     dprev_q, dcur, rise, dir_oh;
  dir_t           arb_q, arb_d;
  logic           coin_prev_q, arm_q, arm_d, coin_edge, coin_out;
  coin_state_t    cst_q, cst_d;
  logic [CCW-1:0] ccnt_q, ccnt_d;
  logic [7:0]     ip1710_q, ip1710_d, ip4740_q, ip4740_d;
  logic           unused_hi;

  assign unused_hi = ^joy_in[15:12];

  assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

  input_debounce #(
    .WIDTH     (12),
    .DEB_TICKS (DEB_TICKS)
  ) u_deb (
    .clk_sys (clk_sys),
    .reset   (reset),
    .tick    (tick),
    .din     (sync2_q),
    .dout    (d)
  );

  assign dcur = {d[JOY_LT], d[JOY_RT], d[JOY_UP], d[JOY_DN]};
  assign rise = dcur & ~dprev_q;

  always_comb begin
    arb_d = arb_q;
    if (|rise) begin
      arb_d = dir_pick(rise);
    end else if (~|(dir_onehot(arb_q) & dcur)) begin
      arb_d = dir_pick(dcur);
    end
  end

  // A coin held through reset must be released before it can arm.
  assign arm_d     = arm_q | (tick & ~sync2_q[JOY_COIN]);
  assign coin_edge = d[JOY_COIN] & ~coin_prev_q & arm_q;

  always_comb begin
    cst_d  = cst_q;
    ccnt_d = ccnt_q;
    unique case (cst_q)
      IDLE: begin
        if (coin_edge) begin
          cst_d  = PULSE;
          ccnt_d = '0;
        end
      end
      PULSE: begin
        if (ccnt_q == CCW'(COIN_ON_TICKS)) begin
          cst_d  = GAP;
          ccnt_d = '0;
        end else if (tick) begin
          ccnt_d = ccnt_q + CCW'(1);
        end
      end
      GAP: begin
        if (ccnt_q == CCW'(COIN_OFF_TICKS)) begin
          cst_d  = d[JOY_COIN] ? WAIT_REL : IDLE;
          ccnt_d = '0;
        end else if (tick) begin
          ccnt_d = ccnt_q + CCW'(1);
        end
      end
      WAIT_REL: begin
        if (!d[JOY_COIN]) cst_d = IDLE;
      end
      default: cst_d = IDLE;
    endcase
  end

  assign coin_out  = (cst_q == PULSE);
  assign coin_busy = (cst_q != IDLE);
  assign dir_oh    = dir_onehot(arb_q);

  always_comb begin
    ip1710_d = {d[JOY_B1], ~tsw_q, 3'b000, coin_out,
                d[JOY_S2], d[JOY_S1]};
    ip4740_d = {4'b0000, dir_oh};
    unique case (1'b1)
      (mod == MOD_MPLANETS): begin
        ip1710_d = {tsw_q, d[JOY_B3], 5'b00000, coin_out};
        ip4740_d = {d[JOY_B2], d[JOY_S2], d[JOY_S1], d[JOY_B1],
                    d[JOY_LT], d[JOY_RT], d[JOY_UP], d[JOY_DN]};
      end
      (mod == MOD_CURVEBAL): begin
        ip1710_d = {5'b00000, coin_out, d[JOY_B2], ~tsw_q};
        ip4740_d = {1'b0, d[JOY_B3], 1'b0, d[JOY_B5],
                    1'b0, d[JOY_B4], d[JOY_B1], 1'b0};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      tick_cnt_q  <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      tsw_q       <= 1'b0;
      dprev_q     <= '0;
      arb_q       <= NONE;
      coin_prev_q <= 1'b0;
      arm_q       <= 1'b0;
      cst_q       <= IDLE;
      ccnt_q      <= '0;
      ip1710_q    <= 8'h00;
      ip4740_q    <= 8'h00;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      sync1_q     <= joy_in[11:0];
      sync2_q     <= sync1_q;
      tsw_q       <= test_sw;
      dprev_q     <= dcur;
      arb_q       <= arb_d;
      coin_prev_q <= d[JOY_COIN];
      arm_q       <= arm_d;
      cst_q       <= cst_d;
      ccnt_q      <= ccnt_d;
      ip1710_q    <= ip1710_d;
      ip4740_q    <= ip4740_d;
    end
  end

  assign ip1710 = ip1710_q;
  assign ip4740 = ip4740_q;

endmodule

// File: tb/tb_mylstar_input_cond.sv
// Directed self-checking bench for mylstar_input_cond.
// Small tick/coin timings keep the run short.
module tb_mylstar_input_cond;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [15:0] joy_in;
  logic        test_sw;
  logic [7:0]  mod;
  logic [7:0]  ip1710, ip4740;
  logic        coin_busy;

  int nchk = 0;
  int nerr = 0;
  int pc   = 0;

  mylstar_input_cond #(
    .TICK_DIV       (10),
    .DEB_TICKS      (4),
    .COIN_ON_TICKS  (6),
    .COIN_OFF_TICKS (6)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .joy_in    (joy_in),
    .test_sw   (test_sw),
    .mod       (mod),
    .ip1710    (ip1710),
    .ip4740    (ip4740),
    .coin_busy (coin_busy)
  );

  always #5 clk_sys = ~clk_sys;

  // posedges since reset release; ticks land on multiples of 10
  always @(posedge clk_sys) begin
    if (reset) pc <= 0;
    else pc <= pc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  function automatic logic [7:0] sel_val(input int sel);
    case (sel)
      0:       return ip1710;
      1:       return ip4740;
      default: return {7'b0, coin_busy};
    endcase
  endfunction

  task automatic wait_val(input int sel, input logic [7:0] e,
                          input int lim, input string tag);
    int k;
    k = 0;
    while (sel_val(sel) !== e && k < lim) begin
      cyc(1);
      k++;
    end
    chk(tag, sel_val(sel), e);
  endtask

  task automatic count_coin(input int n, output int hi, output int ri);
    logic prev;
    prev = ip1710[2];
    hi = 0;
    ri = 0;
    for (int k = 0; k < n; k++) begin
      cyc(1);
      if (ip1710[2]) hi++;
      if (ip1710[2] && !prev) ri++;
      prev = ip1710[2];
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int p0, t1, seen, stable, nz, hi, ri;

    reset   = 1'b1;
    joy_in  = 16'hFFFF;
    test_sw = 1'b0;
    mod     = 8'h00;
    cyc(3);
    chk("rst_1710", ip1710, 8'h00);
    chk("rst_4740", ip4740, 8'h00);
    chk("rst_busy", coin_busy, 0);
    reset  = 1'b0;
    joy_in = 16'h0000;
    cyc(2);
    chk("post_rst_1710", ip1710, 8'h40);
    chk("post_rst_4740", ip4740, 8'h00);
    cyc(30);

    // short glitch: two ticks only
    joy_in = 16'h0001;
    nz = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      if (ip4740 != 8'h00) nz++;
    end
    joy_in = 16'h0000;
    for (int k = 0; k < 80; k++) begin
      cyc(1);
      if (ip4740 != 8'h00) nz++;
    end
    chk("deb_glitch", nz, 0);

    // held press: flips on 4th counted tick, +2 register stages
    joy_in = 16'h0001;
    p0 = pc;
    t1 = ((p0 + 3 + 9) / 10) * 10;
    seen = -1;
    stable = 1;
    for (int k = 0; k < 50; k++) begin
      cyc(1);
      if (seen < 0 && ip4740 == 8'h01) seen = pc;
      else if (seen >= 0 && ip4740 != 8'h01) stable = 0;
      else if (seen < 0 && ip4740 != 8'h00) stable = 0;
    end
    chk("deb_latency", seen, t1 + 32);
    chk("deb_stable", stable, 1);

    // arbiter: last pressed wins, fallback on release
    wait_val(1, 8'h01, 80, "arb_dn");
    joy_in = 16'h0005;
    wait_val(1, 8'h04, 80, "arb_rt_over_dn");
    joy_in = 16'h0001;
    wait_val(1, 8'h01, 80, "arb_fallback_dn");
    joy_in = 16'h0000;
    wait_val(1, 8'h00, 80, "arb_none");
    joy_in = 16'h000A;
    wait_val(1, 8'h02, 80, "arb_up_lt_tie");
    cyc(20);
    chk("arb_tie_hold", ip4740, 8'h02);
    joy_in = 16'h0000;
    wait_val(1, 8'h00, 80, "arb_release");

    // coin held long: exactly one 60-cycle pulse
    joy_in = 16'h0080;
    count_coin(1000, hi, ri);
    chk("coin_width", hi, 60);
    chk("coin_rises", ri, 1);
    chk("coin_busy_held", coin_busy, 1);
    joy_in = 16'h0000;
    wait_val(2, 8'h00, 200, "coin_release");

    // short press: GAP exits straight to IDLE, re-press 1 tick later
    cyc(20);
    joy_in = 16'h0080;
    cyc(60);
    joy_in = 16'h0000;
    wait_val(2, 8'h01, 100, "coin_b_start");
    wait_val(2, 8'h00, 200, "coin_b_gap_end");
    cyc(10);
    joy_in = 16'h0080;
    count_coin(300, hi, ri);
    chk("coin_b2_width", hi, 60);
    chk("coin_b2_rises", ri, 1);
    joy_in = 16'h0000;
    wait_val(2, 8'h00, 200, "coin_b2_idle");
    cyc(60);

    // per-game mapping
    mod = 8'd2;
    joy_in = 16'h0120;
    wait_val(1, 8'hA0, 80, "map_mp_4740");
    chk("map_mp_1710", ip1710, 8'h00);
    test_sw = 1'b1;
    cyc(3);
    chk("map_mp_test", ip1710, 8'h80);
    test_sw = 1'b0;
    cyc(3);
    mod = 8'd4;
    joy_in = 16'h0800;
    wait_val(1, 8'h10, 80, "map_cb_4740");
    cyc(60);
    chk("map_cb_1710", ip1710, 8'h01);
    mod = 8'hFF;
    joy_in = 16'h0000;
    cyc(60);
    chk("map_ff_1710", ip1710, 8'h40);
    chk("map_ff_4740", ip4740, 8'h00);
    joy_in = 16'h0001;
    wait_val(1, 8'h01, 80, "map_ff_dn");
    mod = 8'd0;
    joy_in = 16'h0010;
    wait_val(0, 8'hC0, 80, "map_q_btn1");
    mod = 8'd2;
    cyc(1);
    chk("map_switch_4740", ip4740, 8'h10);
    chk("map_switch_1710", ip1710, 8'h00);
    mod = 8'd0;
    joy_in = 16'h0000;
    cyc(80);

    // async reset in the middle of a pulse
    joy_in = 16'h0080;
    wait_val(0, 8'h44, 100, "ar_pulse_on");
    cyc(10);
    @(posedge clk_sys);
    #2 reset = 1'b1;
    #1;
    chk("ar_coin_drop", ip1710[2], 0);
    chk("ar_busy_drop", coin_busy, 0);
    @(negedge clk_sys);
    cyc(2);
    reset = 1'b0;
    nz = 0;
    for (int k = 0; k < 400; k++) begin
      cyc(1);
      if (coin_busy || ip1710[2]) nz++;
    end
    chk("ar_no_resume", nz, 0);
    joy_in = 16'h0000;
    cyc(100);
    joy_in = 16'h0080;
    wait_val(2, 8'h01, 100, "ar_fresh_press");
    joy_in = 16'h0000;
    cyc(20);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
